multi_clken_gen: RTL and testbench
==================================

MULTI_CLKEN_GEN -- requirements
Module: multi_clken_gen

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent clock-enable channels (1..5).
REQ-002 Parameter CNT_W, default 8, width of each channel's divide and phase fields.
REQ-003 Parameter DEFAULT_DIV, default 1, divide value loaded into every channel at reset.
REQ-004 Parameter LOCK_CYCLES, default 16, settle length in refclk cycles before lock asserts (>=1).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 refclk  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 ch_en  input  NUM_CH  per-channel run enable; 0 freezes that channel's counter.
REQ-009 sync_in  input  1  one-cycle pulse that realigns all channel counters.
REQ-010 cfg_we  input  1  configuration write strobe.
REQ-011 cfg_ch  input  3  target channel index for the write.
REQ-012 cfg_div  input  CNT_W  new divide value; period = cfg_div+1 cycles.
REQ-013 cfg_phase  input  CNT_W  new phase offset within the period.
REQ-014 clken  output  NUM_CH  per-channel one-cycle enable pulses.
REQ-015 clk_sq  output  NUM_CH  per-channel near-50% square wave at the divided rate.
REQ-016 locked  output  1  high once settle completes with no intervening reconfiguration.
REQ-017 cfg_err  output  1  one-cycle pulse flagging a write to a non-existent channel.

Function
REQ-018 Each channel SHALL hold registered div_i, phase_i and cnt_i, each CNT_W bits wide.
REQ-019 cnt_i SHALL increment each cycle ch_en[i]=1 and SHALL wrap to 0 in the cycle after cnt_i==div_i; with ch_en[i]=0 it holds.
REQ-020 clken[i] SHALL equal locked AND ch_en[i] AND (cnt_i==phase_i), decoded from registers only.
REQ-021 div_i=0 SHALL give clken[i]=1 every cycle while locked and enabled, and clk_sq[i]=1.
REQ-022 clk_sq[i] SHALL be registered, high while cnt_i < (div_i+1)/2 rounded up, gated by locked; for div_i>=1 it is low on at least one cycle per period.
REQ-023 On cfg_we=1 with cfg_ch<NUM_CH: div_cfg_ch <= cfg_div, phase_cfg_ch <= min(cfg_phase, cfg_div), visible next cycle.
REQ-024 A valid write SHALL clear all cnt_i to 0 on the same edge, deassert locked next cycle, and restart the settle counter.
REQ-025 On cfg_we=1 with cfg_ch>=NUM_CH: no state change; cfg_err=1 for exactly the next cycle.
REQ-026 sync_in=1 SHALL clear all cnt_i to 0 on that edge without affecting locked or configuration.
REQ-027 cfg_we (valid) and sync_in in the same cycle: the write applies and counters clear once.
REQ-028 Lock FSM states: SETTLE, LOCKED.
REQ-029 SETTLE: settle counter counts 0..LOCK_CYCLES-1, then enters LOCKED; locked=1 exactly LOCK_CYCLES cycles after reset release or after the last valid write.
REQ-030 LOCKED: a valid write returns to SETTLE with the counter at 0; invalid writes and sync_in are ignored.
REQ-031 Back-to-back valid writes SHALL each restart settle; lock waits for the last.
REQ-032 Counters SHALL run during SETTLE so phase alignment is established before lock.

Reset
REQ-033 While reset=1: cnt_i=0, div_i=DEFAULT_DIV, phase_i=0, FSM=SETTLE with counter 0, clken=0, clk_sq=0, locked=0, cfg_err=0.
REQ-034 Reset SHALL dominate cfg_we and sync_in in the same cycle.
REQ-035 Reset asserted mid-operation SHALL apply REQ-033 on the next edge, discarding any pending configuration.

Verification
REQ-036 Reset release, defaults (NUM_CH=2, DEFAULT_DIV=1, LOCK_CYCLES=16), ch_en=2'b11 -> locked rises on cycle 16; then clken=2'b11 every 2nd cycle; clk_sq toggles every cycle.
REQ-037 Write ch1 div=4 phase=2, then wait for lock -> clken[1] pulses every 5 cycles at cnt=2; clk_sq[1] high 3 cycles, low 2; ch0 unchanged; settle is 16 cycles.
REQ-038 Write ch0 div=3 phase=9 -> stored phase=3; clken[0] pulses on the last cycle of each 4-cycle period.
REQ-039 Write cfg_ch=5 while locked -> cfg_err high 1 cycle; locked stays 1; outputs unchanged.
REQ-040 sync_in while locked and cnt_1=3 -> cnt_1=0 next cycle, pulse timing shifts accordingly, locked stays 1; sync_in together with reset -> reset state.
REQ-041 Write issued on cycle 10 of settle -> locked asserts 16 cycles after that write, not at 16 after reset.

Source files
------------

// File: rtl/multi_clken_gen.sv
// Multi-channel programmable clock-enable generator: per-channel divide/phase
// counters on a single reference clock, gated by a lock FSM that waits for settle.
module multi_clken_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 1,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_in,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clken,
    output logic [NUM_CH-1:0] clk_sq,
    output logic              locked,
    output logic              cfg_err
);

    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
    localparam logic [2:0] NUM_CH_L = 3'(NUM_CH);

    typedef enum logic {SETTLE, LOCKED} lock_state_e;

    lock_state_e       state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  div_q   [NUM_CH];
    logic [CNT_W-1:0]  div_d   [NUM_CH];
    logic [CNT_W-1:0]  phase_q [NUM_CH];
    logic [CNT_W-1:0]  phase_d [NUM_CH];
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic              err_q;
    logic              wr_valid;
    logic              cnt_clear;

    assign wr_valid  = cfg_we && (cfg_ch < NUM_CH_L);
    assign cnt_clear = wr_valid || sync_in;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            SETTLE: begin
                if (wr_valid) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = LOCKED;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            LOCKED: begin
                if (wr_valid) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            default: begin
                state_d  = SETTLE;
                settle_d = '0;
            end
        endcase
    end

    // Square wave is computed from next-state values so it lines up with cnt_q.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]   = div_q[i];
            phase_d[i] = phase_q[i];
            cnt_d[i]   = cnt_q[i];
            if (wr_valid && (cfg_ch == 3'(i))) begin
                div_d[i]   = cfg_div;
                phase_d[i] = (cfg_phase > cfg_div) ? cfg_div : cfg_phase;
            end
            if (cnt_clear) begin
                cnt_d[i] = '0;
            end else if (ch_en[i]) begin
                cnt_d[i] = (cnt_q[i] == div_q[i]) ? '0 : cnt_q[i] + CNT_W'(1);
            end
            sq_d[i] = (state_d == LOCKED) &&
                      ({1'b0, cnt_d[i]} < ({1'b0, div_d[i] >> 1} + (CNT_W+1)'(1)));
        end
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            sq_q     <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                div_q[i]   <= CNT_W'(DEFAULT_DIV);
                phase_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            sq_q     <= sq_d;
            err_q    <= cfg_we && !wr_valid;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
                phase_q[i] <= phase_d[i];
            end
        end
    end

    assign locked  = (state_q == LOCKED);
    assign clk_sq  = sq_q;
    assign cfg_err = err_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            clken[i] = locked && ch_en[i] && (cnt_q[i] == phase_q[i]);
        end
    end

endmodule

// File: tb/tb_multi_clken_gen.sv
// Scoreboarded bench for multi_clken_gen: a cycle model predicts every output,
// plus directed lock-latency measurements after reset and after writes.
module tb_multi_clken_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int DEFDIV = 1;
    localparam int LOCK   = 16;

    logic              refclk;
    logic              reset;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_in;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] clken;
    logic [NUM_CH-1:0] clk_sq;
    logic              locked;
    logic              cfg_err;

    typedef struct packed {
        logic [NUM_CH-1:0] clken;
        logic [NUM_CH-1:0] sq;
        logic              locked;
        logic              err;
    } exp_t;

    exp_t expQ[$];
    int   vecCnt  = 0;
    int   failCnt = 0;
    int   mCnt   [NUM_CH];
    int   mDiv   [NUM_CH];
    int   mPhase [NUM_CH];
    int   mSince = 0;
    logic mErr   = 1'b0;
    int   lockAt;

    multi_clken_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFDIV), .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk(refclk), .reset(reset), .ch_en(ch_en), .sync_in(sync_in),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .clken(clken), .clk_sq(clk_sq), .locked(locked), .cfg_err(cfg_err)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance the reference model across one rising edge using the driven inputs.
    task automatic modelEdge();
        logic valid;
        int   idx;
        valid = cfg_we && (int'(cfg_ch) < NUM_CH);
        idx   = int'(cfg_ch);
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mCnt[i] = 0; mDiv[i] = DEFDIV; mPhase[i] = 0;
            end
            mSince = 0;
            mErr   = 1'b0;
        end else begin
            mErr = cfg_we && !valid;
            for (int i = 0; i < NUM_CH; i++) begin
                if (valid || sync_in) mCnt[i] = 0;
                else if (ch_en[i]) mCnt[i] = (mCnt[i] == mDiv[i]) ? 0 : mCnt[i] + 1;
            end
            if (valid) begin
                mDiv[idx]   = int'(cfg_div);
                mPhase[idx] = (cfg_phase > cfg_div) ? int'(cfg_div) : int'(cfg_phase);
                mSince      = 0;
            end else if (mSince < LOCK) begin
                mSince++;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        e = expQ.pop_front();
        vecCnt++;
        assert (clken === e.clken) else begin
            failCnt++;
            $error("[TB] FAIL %s clken observed=%b expected=%b", tag, clken, e.clken);
        end
        vecCnt++;
        assert (clk_sq === e.sq) else begin
            failCnt++;
            $error("[TB] FAIL %s clk_sq observed=%b expected=%b", tag, clk_sq, e.sq);
        end
        vecCnt++;
        assert (locked === e.locked) else begin
            failCnt++;
            $error("[TB] FAIL %s locked observed=%b expected=%b", tag, locked, e.locked);
        end
        vecCnt++;
        assert (cfg_err === e.err) else begin
            failCnt++;
            $error("[TB] FAIL %s cfg_err observed=%b expected=%b", tag, cfg_err, e.err);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NUM_CH-1:0] en, input logic s,
                                 input logic w, input logic [2:0] c, input logic [CNT_W-1:0] d,
                                 input logic [CNT_W-1:0] p, input string tag);
        exp_t e;
        logic ml;
        reset = r; ch_en = en; sync_in = s; cfg_we = w; cfg_ch = c; cfg_div = d; cfg_phase = p;
        modelEdge();
        ml = (mSince >= LOCK);
        for (int i = 0; i < NUM_CH; i++) begin
            e.clken[i] = ml && en[i] && (mCnt[i] == mPhase[i]);
            e.sq[i]    = ml && (mCnt[i] < (mDiv[i] + 2) / 2);
        end
        e.locked = ml;
        e.err    = mErr;
        expQ.push_back(e);
        @(posedge refclk);
        @(negedge refclk);
        checkOutput(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, tag);
    endtask

    // Step idle cycles until the DUT reports lock; must land exactly LOCK edges after the trigger.
    task automatic waitLock(input string tag);
        lockAt = -1;
        for (int k = 1; k <= 3 * LOCK && lockAt < 0; k++) begin
            applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, tag);
            if (locked === 1'b1) lockAt = k;
        end
        vecCnt++;
        assert (lockAt == LOCK) else begin
            failCnt++;
            $error("[TB] FAIL %s lock_latency observed=%0d expected=%0d", tag, lockAt, LOCK);
        end
    endtask

    initial begin
        reset = 1'b1; ch_en = '0; sync_in = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_phase = '0;

        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, "reset");
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, "reset");
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 3'd1, 8'd4, 8'd2, "reset_dominates");
        waitLock("lock_after_reset");
        idle(6, "default_div1");

        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd1, 8'd4, 8'd2, "wr_ch1_div4");
        waitLock("lock_after_wr_ch1");
        idle(12, "ch1_div4_run");

        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd0, 8'd3, 8'd9, "wr_ch0_phase_clamp");
        waitLock("lock_after_wr_ch0");
        idle(10, "ch0_div3_run");

        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd5, 8'd7, 8'd1, "bad_ch5");
        idle(4, "after_bad_ch5");
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd2, 8'd7, 8'd1, "bad_ch2");
        idle(2, "after_bad_ch2");

        for (int k = 0; k < 6 && mCnt[1] != 3; k++) idle(1, "seek_cnt1_3");
        applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0, "sync_locked");
        idle(8, "after_sync");

        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, "ch1_frozen");
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, "ch0_frozen");
        idle(4, "both_run");

        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd1, 8'd0, 8'd0, "wr_ch1_div0");
        idle(9, "settle_mid");
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd0, 8'd1, 8'd5, "rewrite_in_settle");
        waitLock("lock_after_last_write");
        idle(6, "div0_run");

        applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 3'd0, 8'd2, 8'd1, "wr_and_sync");
        waitLock("lock_after_wr_sync");
        idle(6, "ch0_div2_run");

        applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd1, 8'd6, 8'd3, "wr_before_reset");
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, "mid_reset");
        waitLock("lock_after_mid_reset");
        idle(4, "defaults_again");
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0, "sync_with_reset");
        idle(3, "post_sync_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, failCnt);
        $finish;
    end

endmodule
